// File: rtl/sfx_pkg.sv
// Shared types, sizes and the per-event sound pattern table for the SFX sequencer.
package sfx_pkg;

    localparam int NUM_EVENTS = 4;
    localparam int MAX_STEPS  = 4;
    localparam int STEP_BITS  = 4;
    localparam int ID_W       = $clog2(NUM_EVENTS);
    localparam int STEP_IDX_W = $clog2(MAX_STEPS);

    // Channel mask bits: [2]=noise, [1]=square, [0]=saw
    localparam logic [2:0] MASK_SAW    = 3'b001;
    localparam logic [2:0] MASK_SQUARE = 3'b010;
    localparam logic [2:0] MASK_NOISE  = 3'b100;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]           mask;
        logic [STEP_BITS-1:0] frames;
    } step_t;

    // A zero frame count terminates a pattern.
    localparam step_t STEP_END = '{mask: 3'b000, frames: 4'd0};

    // Indexed [event][step]; event index is also its priority.
    localparam step_t PATTERN_ROM [NUM_EVENTS][MAX_STEPS] = '{
        '{ '{MASK_SQUARE, 4'd4}, '{MASK_SQUARE | MASK_SAW, 4'd4}, STEP_END, STEP_END },
        '{ '{MASK_SQUARE, 4'd6}, STEP_END, STEP_END, STEP_END },
        '{ '{MASK_NOISE, 4'd3}, '{MASK_SAW, 4'd3}, STEP_END, STEP_END },
        '{ '{MASK_NOISE | MASK_SAW, 4'd8}, '{MASK_NOISE, 4'd8}, '{MASK_NOISE, 4'd8}, STEP_END }
    };

    // Index of the highest set bit; 0 when nothing is set.
    function automatic logic [ID_W-1:0] highest_index(input logic [NUM_EVENTS-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sfx_frame_tick.sv
// Produces a one-cycle frame_tick on the first clock where the raster is at (0,0).
module sfx_frame_tick
    import sfx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       frame_tick
);

    logic at_origin_s;
    logic at_origin_r;

    assign at_origin_s = (x == 10'd0) && (y == 10'd0);
    assign frame_tick  = at_origin_s && !at_origin_r;

    // Remember whether the previous cycle was already at the origin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            at_origin_r <= 1'b0;
        end else begin
            at_origin_r <= at_origin_s;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns game-event strobes into frame-aligned channel trigger sequences for the APU.
module sfx_sequencer
    import sfx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_EVENTS-1:0] event_strobe,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    output logic                  saw_trigger,
    output logic                  square_trigger,
    output logic                  noise_trigger,
    output logic                  busy,
    output logic [ID_W-1:0]       active_id
);

    logic                  frame_tick_s;
    state_t                state_r, state_s;
    logic [NUM_EVENTS-1:0] pending_r, pending_s;
    logic [STEP_IDX_W-1:0] step_r, step_s, next_step_s;
    logic [STEP_BITS-1:0]  frames_left_r, frames_left_s;
    logic [ID_W-1:0]       active_id_r, active_id_s;
    logic [NUM_EVENTS-1:0] cand_set_s;
    logic [ID_W-1:0]       cand_id_s;
    logic [2:0]            mask_s;
    logic [2:0]            trig_r;
    logic                  busy_r;

    sfx_frame_tick u_frame_tick (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick_s)
    );

    // Next-state: pending capture, frame-boundary arbitration and step sequencing.
    always_comb begin
        state_s       = state_r;
        pending_s     = pending_r;
        step_s        = step_r;
        frames_left_s = frames_left_r;
        active_id_s   = active_id_r;
        mask_s        = 3'b000;
        cand_set_s    = pending_r | event_strobe;
        cand_id_s     = highest_index(cand_set_s);
        next_step_s   = step_r + STEP_IDX_W'(1);

        if (!enable) begin
            // Mute and flush; strobes are ignored while disabled.
            state_s       = IDLE;
            pending_s     = '0;
            step_s        = '0;
            frames_left_s = '0;
            active_id_s   = '0;
        end else if (!frame_tick_s) begin
            pending_s = cand_set_s;
        end else begin
            // Pending is consumed or dropped on every frame boundary.
            pending_s = '0;
            if ((cand_set_s != '0) && ((state_r == IDLE) || (cand_id_s >= active_id_r))) begin
                if (PATTERN_ROM[cand_id_s][STEP_IDX_W'(0)].frames != 4'd0) begin
                    state_s       = PLAY;
                    active_id_s   = cand_id_s;
                    step_s        = '0;
                    frames_left_s = PATTERN_ROM[cand_id_s][STEP_IDX_W'(0)].frames;
                end else begin
                    // Empty pattern: "no sound".
                    state_s       = IDLE;
                    active_id_s   = '0;
                    step_s        = '0;
                    frames_left_s = '0;
                end
            end else if (state_r == PLAY) begin
                if (frames_left_r > 4'd1) begin
                    frames_left_s = frames_left_r - 4'd1;
                end else if ((step_r == STEP_IDX_W'(MAX_STEPS - 1)) ||
                             (PATTERN_ROM[active_id_r][next_step_s].frames == 4'd0)) begin
                    state_s       = IDLE;
                    active_id_s   = '0;
                    step_s        = '0;
                    frames_left_s = '0;
                end else begin
                    step_s        = next_step_s;
                    frames_left_s = PATTERN_ROM[active_id_r][next_step_s].frames;
                end
            end else begin
                state_s = state_r;
            end
        end

        if (state_s == PLAY) begin
            mask_s = PATTERN_ROM[active_id_s][step_s].mask;
        end else begin
            mask_s = 3'b000;
        end
    end

    // Sequencer state plus registered triggers/busy taken from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            pending_r     <= '0;
            step_r        <= '0;
            frames_left_r <= '0;
            active_id_r   <= '0;
            trig_r        <= 3'b000;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            pending_r     <= pending_s;
            step_r        <= step_s;
            frames_left_r <= frames_left_s;
            active_id_r   <= active_id_s;
            trig_r        <= mask_s;
            busy_r        <= (state_s == PLAY);
        end
    end

    assign saw_trigger    = trig_r[0];
    assign square_trigger = trig_r[1];
    assign noise_trigger  = trig_r[2];
    assign busy           = busy_r;
    assign active_id      = active_id_r;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: a frame-list reference model pushes expected
// outputs per cycle; a monitor pops and compares after every rising edge.
module tb_sfx_sequencer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] event_strobe;
    logic [9:0] x;
    logic [9:0] y;
    logic       saw_trigger;
    logic       square_trigger;
    logic       noise_trigger;
    logic       busy;
    logic [1:0] active_id;

    sfx_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .event_strobe   (event_strobe),
        .x              (x),
        .y              (y),
        .saw_trigger    (saw_trigger),
        .square_trigger (square_trigger),
        .noise_trigger  (noise_trigger),
        .busy           (busy),
        .active_id      (active_id)
    );

    // Sound table as written in the sound list: frames per step, 0 terminates.
    int         pat_len  [4][4] = '{'{4, 4, 0, 0}, '{6, 0, 0, 0}, '{3, 3, 0, 0}, '{8, 8, 8, 0}};
    logic [2:0] pat_mask [4][4] = '{'{3'b010, 3'b011, 3'b000, 3'b000},
                                    '{3'b010, 3'b000, 3'b000, 3'b000},
                                    '{3'b100, 3'b001, 3'b000, 3'b000},
                                    '{3'b101, 3'b100, 3'b100, 3'b000}};

    // Reference model: the playing sound is a list of masks, one per remaining frame.
    bit         m_play;
    int         m_id;
    logic [3:0] m_pending;
    bit         m_prev;
    logic [2:0] m_frames[$];

    logic [5:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        m_play    = 1'b0;
        m_id      = 0;
        m_pending = 4'd0;
        m_prev    = 1'b0;
        m_frames.delete();
    endfunction

    function automatic void model_start(input int c);
        m_frames.delete();
        for (int s = 0; s < 4; s++) begin
            if (pat_len[c][s] == 0) break;
            for (int f = 0; f < pat_len[c][s]; f++) m_frames.push_back(pat_mask[c][s]);
        end
        m_play = (m_frames.size() > 0);
        m_id   = m_play ? c : 0;
    endfunction

    function automatic logic [5:0] model_cycle(input logic [3:0] strobe, input bit en, input bit origin);
        bit         tick;
        bit         started;
        logic [3:0] cand;
        int         c;
        tick   = origin && !m_prev;
        m_prev = origin;
        if (!en) begin
            m_pending = 4'd0;
            m_play    = 1'b0;
            m_id      = 0;
            m_frames.delete();
        end else begin
            cand = m_pending | strobe;
            if (!tick) begin
                m_pending = cand;
            end else begin
                m_pending = 4'd0;
                started   = 1'b0;
                if (cand != 4'd0) begin
                    c = 0;
                    for (int i = 0; i < 4; i++) if (cand[i]) c = i;
                    if (!m_play || c >= m_id) begin
                        model_start(c);
                        started = 1'b1;
                    end
                end
                if (!started && m_play) begin
                    void'(m_frames.pop_front());
                    if (m_frames.size() == 0) begin
                        m_play = 1'b0;
                        m_id   = 0;
                    end
                end
            end
        end
        if (m_play) return {m_frames[0], 1'b1, m_id[1:0]};
        return 6'd0;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the expected outputs.
    task automatic drive(input logic [3:0] strobe, input bit en, input bit origin);
        event_strobe = strobe;
        enable       = en;
        if (origin) begin
            x = 10'd0;
            y = 10'd0;
        end else if ($urandom_range(0, 3) == 0) begin
            x = 10'd0;
            y = 10'($urandom_range(1, 524));
        end else begin
            x = 10'($urandom_range(1, 799));
            y = 10'($urandom_range(0, 524));
        end
        exp_q.push_back(model_cycle(strobe, en, origin));
        @(negedge clk);
    endtask

    task automatic frames(input int n, input int gap);
        repeat (n) begin
            repeat (gap) drive(4'd0, 1'b1, 1'b0);
            drive(4'd0, 1'b1, 1'b1);
        end
    endtask

    task automatic check_zero(input string name);
        logic [5:0] got;
        got = {noise_trigger, square_trigger, saw_trigger, busy, active_id};
        checks++;
        if (got !== 6'd0) begin
            errors++;
            $display("FAIL %s t=%0t got=%b required=%b", name, $time, got, 6'd0);
        end
    endtask

    task automatic reset_midplay();
        reset = 1'b0;
        #1;
        check_zero("reset_midplay");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    initial begin
        logic [5:0] got;
        logic [5:0] exp;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {noise_trigger, square_trigger, saw_trigger, busy, active_id};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL outputs t=%0t got{n,sq,saw,busy,id}=%b required=%b", $time, got, exp);
                end
            end
        end
    end

    initial begin
        event_strobe = 4'd0;
        enable       = 1'b1;
        x            = 10'd5;
        y            = 10'd5;
        reset        = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        #1 check_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // E1 strobed mid-frame: square for 6 frames, then idle.
        repeat (3) drive(4'd0, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        frames(8, 3);

        // E1 restart on equal priority, then preemption by E3 running to completion.
        drive(4'b0010, 1'b1, 1'b0);
        frames(3, 2);
        drive(4'b0010, 1'b1, 1'b0);
        frames(3, 2);
        drive(4'b1000, 1'b1, 1'b0);
        frames(27, 2);

        // E3 playing, lower-priority E0 is dropped.
        drive(4'b1000, 1'b1, 1'b0);
        frames(3, 2);
        drive(4'b0001, 1'b1, 1'b0);
        frames(26, 2);

        // E0+E2 strobed on the tick cycle while idle; origin held for several cycles.
        drive(4'd0, 1'b1, 1'b0);
        drive(4'b0101, 1'b1, 1'b1);
        drive(4'd0, 1'b1, 1'b1);
        drive(4'd0, 1'b1, 1'b1);
        frames(4, 2);
        // Disable one clock during E2 step 1, then ticks must not resume it.
        drive(4'd0, 1'b0, 1'b0);
        frames(5, 2);

        // Reset in the middle of E3 step 1.
        drive(4'b1000, 1'b1, 1'b0);
        frames(10, 2);
        reset_midplay();
        frames(4, 2);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] s;
            bit         en;
            bit         org;
            s   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            en  = ($urandom_range(0, 299) != 0);
            org = ($urandom_range(0, 5) == 0);
            drive(s, en, org);
        end

        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
